// File: rtl/solver_frame_loader.sv
// Byte-serial front end for the Solver: assembles a header plus payload, drives the Solver, waits out its latency and returns the result.
// Optional trailing parity byte per frame: define SOLVER_LOADER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a header byte
// LOAD  | shifting payload (and parity) bytes, idle timer running
// DRIVE | one cycle, registers work_2 and the data port
// WAIT  | latency down-counter running, capture on terminal count
// OUT   | result presented until res_ready handshake
module solver_frame_loader #(
   parameter int ENC_LAT = 3,
   parameter int DEC_LAT = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [1:0]  work_2,
   output logic [59:0] data_1_80,
   output logic [77:0] data_2_96,
   input  logic [77:0] output_1_96,
   input  logic [59:0] output_2_80,
   output logic [77:0] res_data,
   output logic [1:0]  res_mode,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic        err_frame,
   output logic        err_parity
);

   typedef enum logic [2:0] {IDLE, LOAD, DRIVE, WAIT, OUT} state_t;

   localparam logic [5:0] HDR_TAG = 6'b101010;
   localparam logic [7:0] TMO     = 8'(TIMEOUT);
   localparam logic [7:0] LAT_ENC = 8'(ENC_LAT);
   localparam logic [7:0] LAT_DEC = 8'(DEC_LAT);
`ifdef SOLVER_LOADER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam logic [3:0] EXTRA = {3'b000, PAR_EN};

   state_t      state;
   logic [1:0]  mode;
   logic [3:0]  cnt;
   logic [7:0]  tmr;
   logic [7:0]  lat;
   logic [77:0] asmReg;   // the two MSBs of an 80-bit payload fall off the top
`ifdef SOLVER_LOADER_PARITY_EN
   logic [7:0]  parAcc;
`endif
   logic        xfer;

   assign xfer = in_valid && in_ready;
   assign busy = (state != IDLE);

`ifndef SOLVER_LOADER_PARITY_EN
   assign err_parity = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= IDLE;
         mode      <= 2'd0;
         cnt       <= 4'd0;
         tmr       <= 8'd0;
         lat       <= 8'd0;
         asmReg    <= '0;
         in_ready  <= 1'b0;
         work_2    <= 2'd0;
         data_1_80 <= '0;
         data_2_96 <= '0;
         res_data  <= '0;
         res_mode  <= 2'd0;
         res_valid <= 1'b0;
         err_frame <= 1'b0;
`ifdef SOLVER_LOADER_PARITY_EN
         parAcc     <= 8'd0;
         err_parity <= 1'b0;
`endif
      end else begin
         err_frame <= 1'b0;
`ifdef SOLVER_LOADER_PARITY_EN
         err_parity <= 1'b0;
`endif
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (xfer) begin
                  if (in_byte[7:2] != HDR_TAG || in_byte[1:0] == 2'd3) begin
                     err_frame <= 1'b1;
                  end else begin
                     mode <= in_byte[1:0];
                     tmr  <= TMO;
`ifdef SOLVER_LOADER_PARITY_EN
                     parAcc <= in_byte;
`endif
                     case (in_byte[1:0])
                        2'd0:    cnt <= 4'd8 + EXTRA;
                        2'd1:    cnt <= 4'd10 + EXTRA;
                        default: cnt <= EXTRA;
                     endcase
                     if (in_byte[1:0] == 2'd2 && !PAR_EN) begin
                        state    <= DRIVE;
                        in_ready <= 1'b0;
                     end else begin
                        state <= LOAD;
                     end
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  tmr <= TMO;
                  cnt <= cnt - 4'd1;
                  if (!(PAR_EN && cnt == 4'd1))
                     asmReg <= {asmReg[69:0], in_byte};
`ifdef SOLVER_LOADER_PARITY_EN
                  parAcc <= parAcc ^ in_byte;
                  if (cnt == 4'd1) begin
                     if (in_byte != parAcc) begin
                        err_parity <= 1'b1;
                        state      <= IDLE;
                     end else begin
                        state    <= DRIVE;
                        in_ready <= 1'b0;
                     end
                  end
`else
                  if (cnt == 4'd1) begin
                     state    <= DRIVE;
                     in_ready <= 1'b0;
                  end
`endif
               end else if (tmr <= 8'd1) begin
                  err_frame <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tmr <= tmr - 8'd1;
               end
            end
            DRIVE: begin
               work_2 <= mode;
               if (mode == 2'd0)
                  data_1_80 <= asmReg[59:0];
               else if (mode == 2'd1)
                  data_2_96 <= asmReg;
               lat   <= (mode == 2'd0) ? LAT_ENC : LAT_DEC;
               state <= WAIT;
            end
            WAIT: begin
               if (lat <= 8'd1) begin
                  res_data <= (mode == 2'd0) ? output_1_96 : {18'd0, output_2_80};
                  res_mode <= mode;
                  state    <= OUT;
               end else begin
                  lat <= lat - 8'd1;
               end
            end
            OUT: begin
               // valid rises one cycle after capture so it never coincides with an error pulse
               if (!res_valid) begin
                  res_valid <= 1'b1;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_solver_frame_loader.sv
// Randomized self-checking bench for solver_frame_loader with a frame-level reference model.
module tb_solver_frame_loader;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic [7:0]  in_byte = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  work_2;
   logic [59:0] data_1_80;
   logic [77:0] data_2_96;
   logic [77:0] output_1_96 = '0;
   logic [59:0] output_2_80 = '0;
   logic [77:0] res_data;
   logic [1:0]  res_mode;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        busy;
   logic        err_frame;
   logic        err_parity;

   solver_frame_loader dut (
      .Clk(Clk), .Rst_n(Rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .work_2(work_2), .data_1_80(data_1_80), .data_2_96(data_2_96),
      .output_1_96(output_1_96), .output_2_80(output_2_80),
      .res_data(res_data), .res_mode(res_mode), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .err_frame(err_frame), .err_parity(err_parity)
   );

   localparam int ENC_LAT = 3;
   localparam int DEC_LAT = 2;

   always #5 Clk = ~Clk;

   int edgeCnt = 0;
   always @(posedge Clk) edgeCnt <= edgeCnt + 1;

   // h1[k]/h2[k]: Solver output value present at rising edge number k
   logic [77:0] h1 [0:1023];
   logic [59:0] h2 [0:1023];
   always @(negedge Clk) begin
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      output_1_96 = r[77:0];
      output_2_80 = r[91:32];
      h1[(edgeCnt + 1) % 1024] = r[77:0];
      h2[(edgeCnt + 1) % 1024] = r[91:32];
   end

   int errCnt = 0;
   int parCnt = 0;
   always @(negedge Clk) begin
      if (err_frame)  errCnt = errCnt + 1;
      if (err_parity) parCnt = parCnt + 1;
   end

   int nCmp = 0;
   int nBad = 0;

   logic [59:0] mD1 = '0;
   logic [77:0] mD2 = '0;
   logic [1:0]  mW  = 2'd0;

   // reference: payload bytes concatenated MSB first, truncated to the port width
   function automatic void modelFrame(input logic [1:0] mode, input logic [7:0] b [10], input int n);
      logic [79:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w = (w << 8) | {72'd0, b[i]};
      mW = mode;
      if (mode == 2'd0) mD1 = w[59:0];
      else if (mode == 2'd1) mD2 = w[77:0];
   endfunction

   task automatic sendByte(input logic [7:0] b, input int gap, output int tEdge);
      int k;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge Clk); #1; end
      for (k = 0; k < 50; k++) begin
         if (in_ready) break;
         @(posedge Clk); #1;
      end
      if (k == 50) begin
         nCmp++; nBad++;
         $display("FAIL in_ready_wait: in_ready=%0b required=1", in_ready);
      end
      in_valid = 1'b1;
      in_byte  = b;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      tEdge = edgeCnt;
   endtask

   task automatic runFrame(input logic [7:0] hdr, input logic [7:0] b [10], input int n,
                           input int gapMax, input int holdLow, input bit badPar,
                           output int tLast, output int tValid, output logic [77:0] rData,
                           output logic [1:0] rMode, output bit stable, output bit inRdyLow,
                           output logic [59:0] s1, output logic [77:0] s2, output logic [1:0] sw);
      logic [7:0] par;
      res_ready = 1'b0;
      par = hdr;
      sendByte(hdr, 0, tLast);
      for (int i = 0; i < n; i++) begin
         par = par ^ b[i];
         sendByte(b[i], $urandom_range(gapMax, 0), tLast);
      end
`ifdef SOLVER_LOADER_PARITY_EN
      sendByte(badPar ? (par ^ 8'h01) : par, 0, tLast);
`endif
      tValid = -1; rData = '0; rMode = 2'd0; stable = 1'b0; inRdyLow = 1'b0;
      s1 = data_1_80; s2 = data_2_96; sw = work_2;
      for (int k = 0; k < 40; k++) begin
         @(posedge Clk); #1;
         if (k == 0) begin s1 = data_1_80; s2 = data_2_96; sw = work_2; end
         if (res_valid) begin tValid = edgeCnt; break; end
      end
      if (tValid >= 0) begin
         rData = res_data; rMode = res_mode; stable = 1'b1; inRdyLow = !in_ready;
         repeat (holdLow) begin
            @(posedge Clk); #1;
            if (!res_valid || res_data !== rData || res_mode !== rMode) stable = 1'b0;
            if (in_ready) inRdyLow = 1'b0;
         end
         res_ready = 1'b1;
         @(posedge Clk); #1;
         res_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      #12;
      nCmp++;
      if ({in_ready, work_2, data_1_80, data_2_96, res_data, res_mode, res_valid, busy, err_frame, err_parity} !== '0) begin
         nBad++;
         $display("FAIL reset_outputs: in_ready=%0b busy=%0b res_valid=%0b work_2=%0d required all 0", in_ready, busy, res_valid, work_2);
      end
      @(negedge Clk); Rst_n = 1'b1;
      @(posedge Clk); #1;
      nCmp++;
      if (in_ready !== 1'b1) begin nBad++; $display("FAIL reset_in_ready_rise: got %0b required 1", in_ready); end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] b [10];
      int t, tv; logic [77:0] rd; logic [1:0] rm; bit st, ir; logic [59:0] s1; logic [77:0] s2; logic [1:0] sw;
      sendByte(8'hA8, 0, t);
      for (int i = 0; i < 4; i++) sendByte(8'($urandom()), 0, t);
      Rst_n = 1'b0;
      #2;
      nCmp++;
      if ({in_ready, work_2, data_1_80, data_2_96, res_data, res_mode, res_valid, busy, err_frame, err_parity} !== '0) begin
         nBad++;
         $display("FAIL reset_mid_load: busy=%0b in_ready=%0b required all 0", busy, in_ready);
      end
      @(negedge Clk); Rst_n = 1'b1;
      mD1 = '0; mD2 = '0; mW = 2'd0;
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom());
      runFrame(8'hA8, b, 8, 0, 0, 1'b0, t, tv, rd, rm, st, ir, s1, s2, sw);
      modelFrame(2'd0, b, 8);
      nCmp++;
      if (s1 !== mD1 || tv !== t + 2 + ENC_LAT || rd !== h1[(t + 1 + ENC_LAT) % 1024]) begin
         nBad++;
         $display("FAIL post_reset_frame: data=%h lat=%0d res=%h required data=%h lat=%0d res=%h",
                  s1, tv - t, rd, mD1, 2 + ENC_LAT, h1[(t + 1 + ENC_LAT) % 1024]);
      end
   endtask

   task automatic test_encrypt();
      logic [7:0] b [10];
      int t, tv; logic [77:0] rd; logic [1:0] rm; bit st, ir; logic [59:0] s1; logic [77:0] s2; logic [1:0] sw;
      b = '{8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
      runFrame(8'hA8, b, 8, 0, 0, 1'b0, t, tv, rd, rm, st, ir, s1, s2, sw);
      nCmp++;
      if (s1 !== 60'hFFFFFFFFFFFFFFF || sw !== 2'd0) begin
         nBad++; $display("FAIL enc_ports: data_1_80=%h work_2=%0d required FFFFFFFFFFFFFFF/0", s1, sw);
      end
      nCmp++;
      if (tv - t !== 5) begin nBad++; $display("FAIL enc_latency: got %0d required 5", tv - t); end
      nCmp++;
      if (rd !== h1[(t + 4) % 1024] || rm !== 2'd0) begin
         nBad++; $display("FAIL enc_result: res=%h mode=%0d required %h/0", rd, rm, h1[(t + 4) % 1024]);
      end
      modelFrame(2'd0, b, 8);
   endtask

   task automatic test_decrypt();
      logic [7:0] b [10];
      int t, tv; logic [77:0] rd; logic [1:0] rm; bit st, ir; logic [59:0] s1; logic [77:0] s2; logic [1:0] sw;
      for (int i = 0; i < 10; i++) b[i] = 8'h55;
      runFrame(8'hA9, b, 10, 0, 0, 1'b0, t, tv, rd, rm, st, ir, s1, s2, sw);
      nCmp++;
      if (s2 !== 78'h15555555555555555555 || sw !== 2'd1) begin
         nBad++; $display("FAIL dec_ports: data_2_96=%h work_2=%0d required 15555555555555555555/1", s2, sw);
      end
      nCmp++;
      if (tv - t !== 4) begin nBad++; $display("FAIL dec_latency: got %0d required 4", tv - t); end
      nCmp++;
      if (rd !== {18'd0, h2[(t + 3) % 1024]} || rm !== 2'd1) begin
         nBad++; $display("FAIL dec_result: res=%h mode=%0d required %h/1", rd, rm, {18'd0, h2[(t + 3) % 1024]});
      end
      modelFrame(2'd1, b, 10);
   endtask

   task automatic test_replay_backpressure();
      logic [7:0] b [10];
      int t, tv; logic [77:0] rd; logic [1:0] rm; bit st, ir; logic [59:0] s1; logic [77:0] s2; logic [1:0] sw;
      b = '{default: 8'h00};
      runFrame(8'hAA, b, 0, 0, 6, 1'b0, t, tv, rd, rm, st, ir, s1, s2, sw);
      modelFrame(2'd2, b, 0);
      nCmp++;
      if (sw !== 2'd2 || s2 !== mD2 || s1 !== mD1) begin
         nBad++; $display("FAIL replay_ports: work_2=%0d data_2_96=%h required 2/%h", sw, s2, mD2);
      end
      nCmp++;
      if (rd !== {18'd0, h2[(t + 1 + DEC_LAT) % 1024]} || rm !== 2'd2 || tv - t !== 2 + DEC_LAT) begin
         nBad++; $display("FAIL replay_result: res=%h mode=%0d lat=%0d required %h/2/%0d",
                          rd, rm, tv - t, {18'd0, h2[(t + 1 + DEC_LAT) % 1024]}, 2 + DEC_LAT);
      end
      nCmp++;
      if (!st || !ir) begin nBad++; $display("FAIL replay_hold: stable=%0b in_ready_low=%0b required 1/1", st, ir); end
      nCmp++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         nBad++; $display("FAIL replay_release: busy=%0b res_valid=%0b required 0/0", busy, res_valid);
      end
   endtask

   task automatic test_errors();
      int t, e0;
      logic [59:0] p1; logic [77:0] p2; logic [1:0] pw;
      e0 = errCnt; p1 = data_1_80; p2 = data_2_96; pw = work_2;
      sendByte(8'h28, 0, t);
      sendByte(8'hAB, 0, t);
      @(posedge Clk); #1;
      nCmp++;
      if (errCnt - e0 !== 2 || busy !== 1'b0) begin
         nBad++; $display("FAIL err_header_mode: pulses=%0d busy=%0b required 2/0", errCnt - e0, busy);
      end
      sendByte(8'hA8, 0, t);
      repeat (250) begin @(posedge Clk); #1; end
      nCmp++;
      if (busy !== 1'b1) begin nBad++; $display("FAIL err_timeout_early: busy=%0b required 1", busy); end
      repeat (6) begin @(posedge Clk); #1; end
      nCmp++;
      if (errCnt - e0 !== 3 || busy !== 1'b0) begin
         nBad++; $display("FAIL err_timeout: pulses=%0d busy=%0b required 3/0", errCnt - e0, busy);
      end
      nCmp++;
      if (data_1_80 !== p1 || data_2_96 !== p2 || work_2 !== pw) begin
         nBad++; $display("FAIL err_ports_touched: work_2=%0d required %0d", work_2, pw);
      end
   endtask

   task automatic test_random_back_to_back();
      logic [7:0] b [10];
      logic [1:0] mode;
      logic [77:0] exp;
      int n, lat, t, tv; logic [77:0] rd; logic [1:0] rm; bit st, ir; logic [59:0] s1; logic [77:0] s2; logic [1:0] sw;
      for (int f = 0; f < 20; f++) begin
         mode = 2'($urandom_range(2, 0));
         n = (mode == 2'd0) ? 8 : (mode == 2'd1) ? 10 : 0;
         for (int i = 0; i < 10; i++) b[i] = 8'($urandom());
         runFrame({6'b101010, mode}, b, n, 2, $urandom_range(3, 0), 1'b0, t, tv, rd, rm, st, ir, s1, s2, sw);
         modelFrame(mode, b, n);
         lat = (mode == 2'd0) ? ENC_LAT : DEC_LAT;
         exp = (mode == 2'd0) ? h1[(t + 1 + lat) % 1024] : {18'd0, h2[(t + 1 + lat) % 1024]};
         nCmp++;
         if (s1 !== mD1 || s2 !== mD2 || sw !== mW) begin
            nBad++; $display("FAIL rnd_ports f%0d: d1=%h d2=%h w=%0d required %h/%h/%0d", f, s1, s2, sw, mD1, mD2, mW);
         end
         nCmp++;
         if (tv - t !== 2 + lat) begin nBad++; $display("FAIL rnd_latency f%0d: got %0d required %0d", f, tv - t, 2 + lat); end
         nCmp++;
         if (rd !== exp || rm !== mode) begin
            nBad++; $display("FAIL rnd_result f%0d: res=%h mode=%0d required %h/%0d", f, rd, rm, exp, mode);
         end
         nCmp++;
         if (!st) begin nBad++; $display("FAIL rnd_hold f%0d: stable=%0b required 1", f, st); end
      end
   endtask

`ifdef SOLVER_LOADER_PARITY_EN
   task automatic test_parity();
      logic [7:0] b [10];
      int p0, t, tv; logic [77:0] rd; logic [1:0] rm; bit st, ir; logic [59:0] s1; logic [77:0] s2; logic [1:0] sw;
      logic [59:0] prev;
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom());
      b[0] = b[0] ^ 8'h80;
      prev = data_1_80; p0 = parCnt;
      runFrame(8'hA8, b, 8, 0, 0, 1'b1, t, tv, rd, rm, st, ir, s1, s2, sw);
      nCmp++;
      if (parCnt - p0 !== 1 || tv !== -1 || data_1_80 !== prev) begin
         nBad++; $display("FAIL parity_bad: pulses=%0d valid_edge=%0d data=%h required 1/-1/%h", parCnt - p0, tv, data_1_80, prev);
      end
      runFrame(8'hA8, b, 8, 1, 0, 1'b0, t, tv, rd, rm, st, ir, s1, s2, sw);
      modelFrame(2'd0, b, 8);
      nCmp++;
      if (s1 !== mD1 || tv - t !== 2 + ENC_LAT || rd !== h1[(t + 1 + ENC_LAT) % 1024] || parCnt - p0 !== 1) begin
         nBad++; $display("FAIL parity_good: data=%h lat=%0d res=%h required %h/%0d/%h",
                          s1, tv - t, rd, mD1, 2 + ENC_LAT, h1[(t + 1 + ENC_LAT) % 1024]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_load();
      test_encrypt();
      test_decrypt();
      test_replay_backpressure();
      test_errors();
      test_random_back_to_back();
`ifdef SOLVER_LOADER_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
